// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame parser and its helpers.
package uart_pkg;

    // Frame assembly states
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_e;

    // Reason codes reported on err_code
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    // Default frame start byte
    localparam logic [7:0] DEFAULT_HEADER = 8'hAA;

    // 8-bit wrap-around checksum accumulation
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/uart_timeout_cnt.sv
// Saturating inter-byte timeout counter. Counts while en is high, restarts on
// clr, and flags expiry once it has reached TIMEOUT_CYC-1. Never wraps.
module uart_timeout_cnt #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    import uart_pkg::*;

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: restart on clr, otherwise count up and hold at the last value
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_frame_parser.sv
// Assembles fixed-length command frames (header, payload, checksum) from the
// UART receiver byte stream. Good frames are published as one wide word with a
// one-cycle strobe; bad frames are dropped and flagged with a reason code.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a header byte with good parity
//   PAYLOAD | collecting PAYLOAD_LEN data bytes into the shift register
//   CHECK   | waiting for the checksum byte, then publish or drop
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter int         PAYLOAD_LEN = 4,
    parameter logic [7:0] HEADER      = DEFAULT_HEADER,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     rx_parity_ok,
    output logic [8*PAYLOAD_LEN-1:0] frame_data,
    output logic                     frame_valid,
    output logic                     frame_err,
    output logic [1:0]               err_code,
    output logic [7:0]               good_cnt,
    output logic                     busy
);

    localparam int DW    = 8 * PAYLOAD_LEN;
    localparam int IDX_W = $clog2(PAYLOAD_LEN + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_LEN - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       sum_q, sum_d;
    logic [DW-1:0]    shift_q, shift_d;
    logic [DW-1:0]    frame_data_q, frame_data_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [7:0]       good_cnt_q, good_cnt_d;

    logic             to_clr;
    logic             to_en;
    logic             to_expired;

    // The timer restarts on every byte and is held clear while idle, so entry
    // into PAYLOAD always starts from zero.
    assign to_en  = (state_q != IDLE);
    assign to_clr = rx_valid || (state_q == IDLE);

    uart_timeout_cnt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (to_clr),
        .en     (to_en),
        .expired(to_expired)
    );

    // Next-state and output decode; a received byte always takes priority
    // over a timeout expiring in the same cycle.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        sum_d         = sum_q;
        shift_d       = shift_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        good_cnt_d    = good_cnt_q;

        case (state_q)
            IDLE: begin
                if (rx_valid && rx_parity_ok && (rx_data == HEADER)) begin
                    state_d = PAYLOAD;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end

            PAYLOAD: begin
                if (rx_valid) begin
                    if (!rx_parity_ok) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_PARITY;
                        state_d     = IDLE;
                    end else begin
                        shift_d       = shift_q << 8;
                        shift_d[7:0]  = rx_data;
                        sum_d         = csum_add(sum_q, rx_data);
                        idx_d         = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            state_d = CHECK;
                        end
                    end
                end else if (to_expired) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = IDLE;
                end
            end

            CHECK: begin
                if (rx_valid) begin
                    state_d = IDLE;
                    if (!rx_parity_ok) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_PARITY;
                    end else if (rx_data == sum_q) begin
                        frame_data_d  = shift_q;
                        frame_valid_d = 1'b1;
                        good_cnt_d    = good_cnt_q + 8'd1;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                    end
                end else if (to_expired) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame silently
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            sum_q         <= '0;
            shift_q       <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            good_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            sum_q         <= sum_d;
            shift_q       <= shift_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            good_cnt_q    <= good_cnt_d;
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign good_cnt    = good_cnt_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: frame-level vector table, hand-written timeout
// and reset sequences, then randomized traffic against a queue-based model.
module tb_uart_frame_parser;

    localparam int PL = 4;
    localparam int TO = 20;
    localparam logic [7:0] HDR = 8'hAA;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_parity_ok = 1'b1;
    logic [8*PL-1:0] frame_data;
    logic          frame_valid;
    logic          frame_err;
    logic [1:0]    err_code;
    logic [7:0]    good_cnt;
    logic          busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_frame_parser #(
        .PAYLOAD_LEN(PL),
        .HEADER     (HDR),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_parity_ok(rx_parity_ok),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .err_code    (err_code),
        .good_cnt    (good_cnt),
        .busy        (busy)
    );

    // ---------------- reference model (frame-level view) ----------------
    logic [7:0]  mq[$];          // bytes of the frame in progress, header first
    int          m_gap = 0;      // idle cycles since the last byte of the frame
    logic        e_fv = 0, e_fe = 0;
    logic [1:0]  e_code = 0;
    logic [31:0] e_data = 0;
    logic [7:0]  e_cnt = 0;

    task automatic model_update(input logic r, input logic v, input logic [7:0] d, input logic p);
        logic [7:0]  s;
        logic [31:0] w;
        e_fv = 0;
        e_fe = 0;
        if (r) begin
            mq.delete();
            m_gap = 0; e_code = 0; e_data = 0; e_cnt = 0;
        end else if (mq.size() == 0) begin
            if (v && p && d == HDR) begin
                mq.push_back(d);
                m_gap = 0;
            end
        end else if (v) begin
            m_gap = 0;
            if (!p) begin
                e_fe = 1; e_code = 2'b01; mq.delete();
            end else begin
                mq.push_back(d);
                if (mq.size() == PL + 2) begin
                    s = 0; w = 0;
                    for (int i = 1; i <= PL; i++) begin
                        s = s + mq[i];
                        w = (w << 8) | 32'(mq[i]);
                    end
                    if (s == mq[PL+1]) begin
                        e_fv = 1; e_data = w; e_cnt = e_cnt + 8'd1;
                    end else begin
                        e_fe = 1; e_code = 2'b10;
                    end
                    mq.delete();
                end
            end
        end else begin
            m_gap++;
            if (m_gap == TO) begin
                e_fe = 1; e_code = 2'b11; mq.delete();
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs at the falling edge, sample #1 after the rising
    // edge, advance the model and compare every output against it.
    task automatic step(input logic v, input logic [7:0] d, input logic p);
        @(negedge clk);
        rx_valid     = v;
        rx_data      = d;
        rx_parity_ok = p;
        @(posedge clk);
        #1;
        model_update(rst, v, d, p);
        chk("model_frame_valid", 32'(frame_valid), 32'(e_fv));
        chk("model_frame_err",   32'(frame_err),   32'(e_fe));
        chk("model_err_code",    32'(err_code),    32'(e_code));
        chk("model_frame_data",  frame_data,       e_data);
        chk("model_good_cnt",    32'(good_cnt),    32'(e_cnt));
        chk("model_busy",        32'(busy),        32'(mq.size() != 0));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, 1'b1);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                              input logic [7:0] e, input logic [7:0] cs);
        step(1'b1, HDR, 1'b1);
        step(1'b1, a, 1'b1);
        step(1'b1, b, 1'b1);
        step(1'b1, c, 1'b1);
        step(1'b1, e, 1'b1);
        step(1'b1, cs, 1'b1);
    endtask

    // ---------------- frame vector table ----------------
    typedef struct packed {
        logic [3:0]  n;      // bytes in the record
        logic [63:0] bytes;  // byte 0 in the MS byte
        logic [7:0]  par;    // parity-good mask, bit 7 = byte 0
        logic [1:0]  kind;   // 1 = frame_valid expected, 2 = frame_err expected
        logic [3:0]  at;     // index of the deciding byte
        logic [1:0]  code;   // err_code after the deciding byte
        logic [31:0] data;   // frame_data after the deciding byte
        logic [7:0]  cnt;    // good_cnt after the deciding byte
    } vec_t;

    vec_t tbl [5];

    task automatic gap_rand();
        int r;
        r = $urandom_range(0, 99);
        if (r < 4) idle($urandom_range(TO - 2, TO + 2));
        else       idle($urandom_range(0, 3));
    endtask

    initial begin
        vec_t        v;
        logic [63:0] cur;
        logic [7:0]  b;
        logic        p;
        int          found;
        logic [1:0]  found_code;

        tbl[0] = '{4'd6, 64'hAA01_0203_040A_0000, 8'hFF, 2'd1, 4'd5, 2'b00, 32'h01020304, 8'd1};
        tbl[1] = '{4'd6, 64'hAA01_0203_040B_0000, 8'hFF, 2'd2, 4'd5, 2'b10, 32'h01020304, 8'd1};
        tbl[2] = '{4'd6, 64'hAA10_2030_40A0_0000, 8'hFF, 2'd1, 4'd5, 2'b10, 32'h10203040, 8'd2};
        tbl[3] = '{4'd6, 64'hAA01_0203_040A_0000, 8'hEF, 2'd2, 4'd3, 2'b01, 32'h10203040, 8'd2};
        tbl[4] = '{4'd8, 64'h5512_AAAA_0000_00AA, 8'hFF, 2'd1, 4'd7, 2'b01, 32'hAA000000, 8'd3};

        // reset state
        rst = 1'b1;
        idle(2);
        chk("rst_frame_data", frame_data, 32'h0);
        chk("rst_valid_err",  {30'd0, frame_valid, frame_err}, 32'h0);
        chk("rst_err_code",   32'(err_code), 32'h0);
        chk("rst_good_cnt",   32'(good_cnt), 32'h0);
        chk("rst_busy",       32'(busy), 32'h0);
        rst = 1'b0;
        idle(1);

        // table: bytes spaced 10 cycles apart
        for (int t = 0; t < 5; t++) begin
            v   = tbl[t];
            cur = v.bytes;
            for (int i = 0; i < int'(v.n); i++) begin
                b = cur[63-8*i -: 8];
                p = v.par[7-i];
                step(1'b1, b, p);
                if (i == int'(v.at)) begin
                    if (v.kind == 2'd1) begin
                        chk($sformatf("tbl%0d_valid", t), {30'd0, frame_valid, frame_err}, 32'h2);
                        chk($sformatf("tbl%0d_data", t), frame_data, v.data);
                        chk($sformatf("tbl%0d_cnt", t), 32'(good_cnt), 32'(v.cnt));
                    end else begin
                        chk($sformatf("tbl%0d_err", t), {30'd0, frame_valid, frame_err}, 32'h1);
                        chk($sformatf("tbl%0d_code", t), 32'(err_code), 32'(v.code));
                        chk($sformatf("tbl%0d_data_kept", t), frame_data, v.data);
                        chk($sformatf("tbl%0d_cnt", t), 32'(good_cnt), 32'(v.cnt));
                        chk($sformatf("tbl%0d_busy", t), 32'(busy), 32'h0);
                    end
                end else begin
                    chk($sformatf("tbl%0d_quiet%0d", t, i), {30'd0, frame_valid, frame_err}, 32'h0);
                    if (i > int'(v.at)) chk($sformatf("tbl%0d_idle%0d", t, i), 32'(busy), 32'h0);
                end
                idle(9);
            end
        end

        // timeout: AA 01 then silence; error exactly TO cycles after the 01
        step(1'b1, HDR, 1'b1);
        step(1'b1, 8'h01, 1'b1);
        found = 0;
        found_code = 2'b00;
        for (int k = 1; k <= TO + 5; k++) begin
            step(1'b0, 8'h00, 1'b1);
            if (found == 0 && frame_err) begin
                found = k;
                found_code = err_code;
            end
        end
        chk("timeout_latency", 32'(found), 32'(TO));
        chk("timeout_code", 32'(found_code), 32'h3);
        chk("timeout_busy", 32'(busy), 32'h0);

        // byte landing on the expiry cycle wins, frame completes
        step(1'b1, HDR, 1'b1);
        step(1'b1, 8'h01, 1'b1);
        idle(TO - 1);
        step(1'b1, 8'h02, 1'b1);
        chk("expiry_no_err", 32'(frame_err), 32'h0);
        chk("expiry_busy", 32'(busy), 32'h1);
        step(1'b1, 8'h03, 1'b1);
        step(1'b1, 8'h04, 1'b1);
        step(1'b1, 8'h0A, 1'b1);
        chk("expiry_frame_valid", 32'(frame_valid), 32'h1);
        chk("expiry_frame_data", frame_data, 32'h01020304);

        // back-to-back frames with no idle cycles between them
        send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'hAA);
        chk("b2b_first", frame_data, 32'h11223344);
        send_frame(8'hFF, 8'hFF, 8'h01, 8'h02, 8'h01);
        chk("b2b_second", frame_data, 32'hFFFF0102);

        // reset mid-frame: silent discard, then a clean frame counts from 1
        step(1'b1, HDR, 1'b1);
        step(1'b1, 8'h01, 1'b1);
        rst = 1'b1;
        step(1'b0, 8'h00, 1'b1);
        rst = 1'b0;
        chk("midrst_outputs", {frame_data, 1'b0} == 33'd0 ? 32'h0 : 32'h1, 32'h0);
        chk("midrst_flags", {27'd0, frame_valid, frame_err, busy, err_code}, 32'h0);
        chk("midrst_cnt", 32'(good_cnt), 32'h0);
        idle(3);
        chk("midrst_no_err", 32'(frame_err), 32'h0);
        send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        chk("midrst_frame_valid", 32'(frame_valid), 32'h1);
        chk("midrst_good_cnt", 32'(good_cnt), 32'h1);

        // randomized traffic against the model
        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                step(1'b0, 8'h00, 1'b1);
                rst = 1'b0;
            end
            if ($urandom_range(0, 1) == 1) begin
                logic [7:0] fb [PL+2];
                logic [7:0] s;
                fb[0] = HDR;
                s = 0;
                for (int i = 1; i <= PL; i++) begin
                    fb[i] = ($urandom_range(0, 5) == 0) ? HDR : 8'($urandom_range(0, 255));
                    s = s + fb[i];
                end
                fb[PL+1] = ($urandom_range(0, 9) == 0) ? s ^ 8'h01 : s;
                for (int i = 0; i < PL + 2; i++) begin
                    step(1'b1, fb[i], ($urandom_range(0, 39) != 0));
                    gap_rand();
                end
            end else begin
                for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
                    step(1'b1, ($urandom_range(0, 3) == 0) ? HDR : 8'($urandom_range(0, 255)),
                         ($urandom_range(0, 19) != 0));
                    gap_rand();
                end
            end
        end
        idle(TO + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
